// File: rtl/selftrigger_frame_capture_if.sv
// rtl/selftrigger_frame_capture_if.sv - frame output stream between capture block and packetiser
interface selftrigger_frame_capture_if;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_sof;
    logic        dout_eof;

    modport master (
        output dout,
        output dout_valid,
        output dout_sof,
        output dout_eof,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        input  dout_sof,
        input  dout_eof,
        output dout_ready
    );
endinterface

// File: rtl/selftrigger_frame_capture.sv
// rtl/selftrigger_frame_capture.sv - circular pre-trigger history and framed readout of the self-trigger stream
module selftrigger_frame_capture #(
    parameter int PRE_SAMPLES  = 64,
    parameter int POST_SAMPLES = 192,
    parameter int ADDR_W       = 9
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [15:0]                   x,
    input  logic                          trigger,
    input  logic [63:0]                   timestamp,
    selftrigger_frame_capture_if.master   dout_if,
    output logic                          busy,
    output logic [15:0]                   missed_triggers
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int TOTAL = 4 + PRE_SAMPLES + POST_SAMPLES;

    localparam logic [ADDR_W:0]   PRE_CNT   = (ADDR_W + 1)'(PRE_SAMPLES);
    localparam logic [ADDR_W:0]   POST_CNT  = (ADDR_W + 1)'(POST_SAMPLES);
    localparam logic [ADDR_W:0]   ONE_CNT   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_SAMPLES);
    localparam logic [ADDR_W+1:0] HDR_WORDS = (ADDR_W + 2)'(4);
    localparam logic [ADDR_W+1:0] LAST_WORD = (ADDR_W + 2)'(TOTAL - 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_ARMED,
        S_POST,
        S_READOUT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] rp;
    logic [ADDR_W-1:0] rp_next;
    logic [ADDR_W:0]   fill_cnt;
    logic [ADDR_W:0]   post_cnt;
    logic [ADDR_W+1:0] wcnt;
    logic [63:0]       ts_reg;
    logic              trig_prev;
    logic [15:0]       buf_mem [DEPTH];
    logic [15:0]       rd_data;
    logic [15:0]       hdr_word;
    logic              edge_det;
    logic              wr_en;
    logic              out_load;
    logic              out_done;

    assign busy = (state != S_ARMED);

    // Edge detect, write strobe, output-stage load/finish and look-ahead read address.
    // rp_next is what rp becomes at the next edge, so rd_data always mirrors buf_mem[rp].
    always_comb begin
        edge_det = enable && trigger && !trig_prev;
        wr_en    = enable && (state != S_READOUT);
        out_done = (state == S_READOUT) && dout_if.dout_valid && dout_if.dout_ready && dout_if.dout_eof;
        out_load = (state == S_READOUT) && (!dout_if.dout_valid || dout_if.dout_ready) && (wcnt <= LAST_WORD);
        rp_next  = (out_load && (wcnt >= HDR_WORDS)) ? rp + 1'b1 : rp;
        hdr_word = ts_reg[15:0];
        case (wcnt[1:0])
            2'd0:    hdr_word = ts_reg[63:48];
            2'd1:    hdr_word = ts_reg[47:32];
            2'd2:    hdr_word = ts_reg[31:16];
            default: hdr_word = ts_reg[15:0];
        endcase
    end

    // History memory: sample write plus synchronous read at the look-ahead address.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[wp] <= x;
        end
        rd_data <= buf_mem[rp_next];
    end

    // Capture FSM, pointers, miss counter and the registered output word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= S_FILL;
            wp                 <= '0;
            rp                 <= '0;
            fill_cnt           <= '0;
            post_cnt           <= '0;
            wcnt               <= '0;
            ts_reg             <= '0;
            trig_prev          <= 1'b0;
            missed_triggers    <= '0;
            dout_if.dout       <= '0;
            dout_if.dout_valid <= 1'b0;
            dout_if.dout_sof   <= 1'b0;
            dout_if.dout_eof   <= 1'b0;
        end else begin
            if (enable) begin
                trig_prev <= trigger;
            end
            if (edge_det && (state != S_ARMED) && (missed_triggers != 16'hFFFF)) begin
                missed_triggers <= missed_triggers + 16'd1;
            end
            if (wr_en) begin
                wp <= wp + 1'b1;
            end
            rp <= rp_next;

            case (state)
                S_FILL: begin
                    if (enable) begin
                        fill_cnt <= fill_cnt + 1'b1;
                        if (fill_cnt + 1'b1 == PRE_CNT) begin
                            state <= S_ARMED;
                        end
                    end
                end
                S_ARMED: begin
                    if (edge_det) begin
                        // The frame starts PRE_SAMPLES before the trigger sample being written now.
                        ts_reg   <= timestamp;
                        rp       <= wp - PRE_OFS;
                        post_cnt <= ONE_CNT;
                        wcnt     <= '0;
                        state    <= (POST_SAMPLES == 1) ? S_READOUT : S_POST;
                    end
                end
                S_POST: begin
                    if (enable) begin
                        post_cnt <= post_cnt + 1'b1;
                        if (post_cnt + 1'b1 == POST_CNT) begin
                            state <= S_READOUT;
                        end
                    end
                end
                S_READOUT: begin
                    if (out_done) begin
                        // Refill from scratch so the next frame never reuses stale history.
                        dout_if.dout_valid <= 1'b0;
                        dout_if.dout_sof   <= 1'b0;
                        dout_if.dout_eof   <= 1'b0;
                        fill_cnt           <= '0;
                        state              <= S_FILL;
                    end else if (out_load) begin
                        dout_if.dout       <= (wcnt < HDR_WORDS) ? hdr_word : rd_data;
                        dout_if.dout_sof   <= (wcnt == '0);
                        dout_if.dout_eof   <= (wcnt == LAST_WORD);
                        dout_if.dout_valid <= 1'b1;
                        wcnt               <= wcnt + 1'b1;
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_selftrigger_frame_capture.sv
// tb/tb_selftrigger_frame_capture.sv - scoreboard bench for selftrigger_frame_capture
module tb_selftrigger_frame_capture;

    localparam int PRE  = 64;
    localparam int POST = 192;

    typedef struct {
        logic [15:0] d;
        logic        sof;
        logic        eof;
    } word_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] x;
    logic        trigger;
    logic [63:0] timestamp;
    logic        busy;
    logic [15:0] missed;

    selftrigger_frame_capture_if dif ();

    selftrigger_frame_capture dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .x               (x),
        .trigger         (trigger),
        .timestamp       (timestamp),
        .dout_if         (dif),
        .busy            (busy),
        .missed_triggers (missed)
    );

    always #5 clk = ~clk;

    word_t       sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          hs_cnt   = 0;
    int          samp     = 0;
    int          cyc_n    = 0;
    logic [63:0] tsc      = 64'h100;
    bit          bp_mode  = 0;
    bit          stall_prev = 0;
    logic [15:0] hold_d;
    logic        hold_sof;
    logic        hold_eof;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input int t, input logic [63:0] ts);
        word_t w;
        for (int i = 0; i < 4; i++) begin
            w.d   = ts[63 - 16*i -: 16];
            w.sof = (i == 0);
            w.eof = 1'b0;
            sb.push_back(w);
        end
        for (int k = t - PRE; k <= t + POST - 1; k++) begin
            w.d   = 16'(k);
            w.sof = 1'b0;
            w.eof = (k == t + POST - 1);
            sb.push_back(w);
        end
    endtask

    task automatic monitor();
        word_t e;
        if (reset === 1'b1) begin
            if (stall_prev) begin
                chk("stall_valid", dif.dout_valid, 1'b1);
                chk("stall_data", dif.dout, hold_d);
                chk("stall_sof", dif.dout_sof, hold_sof);
                chk("stall_eof", dif.dout_eof, hold_eof);
            end
            if (dif.dout_valid && dif.dout_ready) begin
                if (sb.size() == 0) begin
                    chk("extra_word_valid", dif.dout_valid, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("word_data", dif.dout, e.d);
                    chk("word_sof", dif.dout_sof, e.sof);
                    chk("word_eof", dif.dout_eof, e.eof);
                    hs_cnt++;
                end
            end
            stall_prev = dif.dout_valid && !dif.dout_ready;
            hold_d     = dif.dout;
            hold_sof   = dif.dout_sof;
            hold_eof   = dif.dout_eof;
        end else begin
            stall_prev = 0;
        end
    endtask

    task automatic cyc(input bit en, input bit trg);
        @(posedge clk);
        #1;
        enable         = en;
        trigger        = trg;
        x              = en ? samp[15:0] : 16'hDEAD;
        timestamp      = tsc;
        tsc            = tsc + 64'd1;
        dif.dout_ready = bp_mode ? ((cyc_n % 3) == 0) : 1'b1;
        cyc_n++;
        if (en) samp++;
        @(negedge clk);
        monitor();
    endtask

    task automatic run(input int n_en, input int period, input int lo, input int hi, input bit cap);
        int fed;
        int ph;
        bit en;
        bit trg;
        fed = 0;
        ph  = 0;
        while (fed < n_en) begin
            en  = (ph % period) == 0;
            trg = (samp >= lo) && (samp <= hi);
            if (cap && en && samp == lo) push_frame(lo, tsc);
            ph++;
            if (en) fed++;
            cyc(en, trg);
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            cyc(1'b0, 1'b0);
            n++;
        end
        chk(tag, sb.size(), 0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);
    endtask

    task automatic reset_dut();
        reset   = 1'b0;
        enable  = 1'b0;
        trigger = 1'b0;
        sb.delete();
        samp    = 0;
        hs_cnt  = 0;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        reset   = 1'b1;
    endtask

    initial begin
        int n;
        reset          = 1'b0;
        enable         = 1'b0;
        trigger        = 1'b0;
        x              = '0;
        timestamp      = '0;
        dif.dout_ready = 1'b1;
        @(negedge clk);
        chk("rst_dout", dif.dout, 16'h0);
        chk("rst_valid", dif.dout_valid, 1'b0);
        chk("rst_sof", dif.dout_sof, 1'b0);
        chk("rst_eof", dif.dout_eof, 1'b0);
        chk("rst_missed", missed, 16'h0);
        chk("rst_busy", busy, 1'b1);

        // Ramp fill, trigger at sample 100
        reset_dut();
        run(100, 1, 1, 0, 0);
        chk("ramp_armed_busy", busy, 1'b0);
        tsc = 64'h0000_0001_0002_0003;
        run(200, 1, 100, 100, 1);
        drain("ramp_drain", 2000);
        chk("ramp_words", hs_cnt, 260);
        chk("ramp_missed", missed, 16'h0);

        // Early trigger in FILL, later capture
        reset_dut();
        run(150, 1, 10, 10, 0);
        chk("early_missed", missed, 16'h1);
        chk("early_no_frame", hs_cnt, 0);
        run(250, 1, 200, 200, 1);
        drain("early_drain", 2000);
        chk("early_words", hs_cnt, 260);

        // Backpressure with ready pattern 1,0,0
        reset_dut();
        bp_mode = 1;
        run(100, 1, 1, 0, 0);
        tsc = 64'h0000_0001_0002_0003;
        run(200, 1, 100, 100, 1);
        drain("bp_drain", 3000);
        chk("bp_words", hs_cnt, 260);
        bp_mode = 0;

        // Held trigger, retrigger during POST, wrapped second frame
        reset_dut();
        run(100, 1, 1, 0, 0);
        run(60, 1, 100, 149, 1);
        run(10, 1, 160, 165, 0);
        chk("retrig_missed_post", missed, 16'h1);
        run(750, 1, 700, 700, 1);
        drain("wrap_drain", 2000);
        chk("wrap_words", hs_cnt, 520);
        chk("wrap_missed", missed, 16'h1);

        // Enable on every third cycle, edge on a non-enable cycle ignored
        reset_dut();
        run(100, 3, 1, 0, 0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        run(300, 3, 150, 150, 1);
        drain("gate_drain", 2000);
        chk("gate_words", hs_cnt, 260);
        chk("gate_missed", missed, 16'h0);

        // Asynchronous reset at header word 2
        reset_dut();
        run(20, 1, 10, 10, 0);
        run(80, 1, 1, 0, 0);
        run(192, 1, 100, 100, 1);
        n = 0;
        while (hs_cnt < 2 && n < 50) begin
            cyc(1'b0, 1'b0);
            n++;
        end
        chk("ar_reach_word2", hs_cnt, 2);
        chk("ar_missed_before", missed, 16'h1);
        #1;
        reset = 1'b0;
        #1;
        chk("ar_valid_drop", dif.dout_valid, 1'b0);
        chk("ar_missed_clear", missed, 16'h0);
        sb.delete();
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 64; i++) begin
            cyc(1'b1, 1'b0);
            chk("ar_busy_fill", busy, 1'b1);
        end
        cyc(1'b1, 1'b0);
        chk("ar_busy_armed", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/selftrigger_frame_capture.md
Name: selftrigger_frame_capture

Overview:
- Sits directly downstream of the IIR/moving-mean/CFD self-trigger stage.
- Consumes that stage's 16-bit sample stream and its trigger level, and keeps a circular pre-trigger history.
- On a trigger rising edge it freezes a frame of PRE_SAMPLES before and POST_SAMPLES from the trigger, then streams it out with ready/valid: 4-word timestamp header followed by the samples, to the channel readout/packetiser.

Parameters:
PRE_SAMPLES, 64, samples stored before the trigger sample (>=1)
POST_SAMPLES, 192, samples stored from the trigger sample onward, trigger sample included (>=1)
ADDR_W, 9, circular buffer address width; PRE_SAMPLES+POST_SAMPLES <= 2**ADDR_W

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  sample strobe; x and trigger are valid only when high
x  in  16  signed sample from upstream stage (its y output)
trigger  in  1  upstream trigger level
timestamp  in  64  free-running timestamp
dout  out  16  output word
dout_valid  out  1  dout holds a valid word
dout_ready  in  1  downstream accepts the word when high together with dout_valid
dout_sof  out  1  high with the first header word
dout_eof  out  1  high with the last sample word
busy  out  1  high in every state except ARMED
missed_triggers  out  16  saturating count of trigger edges not captured

Behaviour:
- All registers are reset asynchronously when reset=0.
- Reset values: dout=0, dout_valid=0, dout_sof=0, dout_eof=0, missed_triggers=0, busy=1, state=FILL, write pointer=0.
- Edge detect: trig_prev is updated only on enable cycles. A trigger edge is trigger=1 && trig_prev=0 && enable=1.
- Buffer write: in FILL, ARMED and POST, each enable cycle writes x to buf[wp] and increments wp modulo 2**ADDR_W. No writes happen in READOUT.
- FILL: counts written samples. After PRE_SAMPLES writes, move to ARMED on the next cycle. Edges seen in FILL increment missed_triggers.
- ARMED (busy=0):
  - On an edge, the trigger sample is written at wp as usual.
  - Latch ts_reg=timestamp and start_ptr=wp-PRE_SAMPLES (mod).
  - post_cnt=1; go to POST, or directly to READOUT if POST_SAMPLES=1.
- POST: write enable samples until post_cnt reaches POST_SAMPLES, then go to READOUT. Further edges increment missed_triggers.
- READOUT: emit 4+PRE_SAMPLES+POST_SAMPLES words.
  - Header words, in order: ts_reg[63:48], [47:32], [31:16], [15:0]; then buf[start_ptr] onward, incrementing rp mod depth.
  - Buffer read is synchronous with 1-cycle latency. The implementation prefetches so the output stage sustains one word per clock while dout_ready=1.
  - dout, dout_sof and dout_eof are registered and stay stable while dout_valid=1 and dout_ready=0.
  - First dout_valid appears at most 2 cycles after entering READOUT.
  - dout_sof is high only on word 0; dout_eof is high only on the last word.
  - After the eof handshake: dout_valid=0, the fill counter clears, and the state returns to FILL. This forces a fresh PRE_SAMPLES refill so the stale history is never reused.
  - Edges during READOUT increment missed_triggers.
- missed_triggers saturates at 16'hFFFF; it is cleared only by reset.
- enable=0: no write, no counter advance, and trig_prev is held. READOUT proceeds independently of enable.
- Simultaneous events: an edge on the cycle FILL completes its last write counts as missed; ARMED begins the following cycle.
- Reset mid-READOUT: dout_valid drops immediately (asynchronously). After release, the block restarts in FILL with wp=0.
- Width rules: post_cnt and the fill counter are ADDR_W+1 bits; the readout word counter is ADDR_W+2 bits. Samples pass through unmodified; no sign handling.

Test Plan:
- Ramp fill: x=0,1,2,… every cycle, enable=1, dout_ready=1, defaults. Pulse trigger at sample 100 with timestamp=64'h0000_0001_0002_0003 → exactly 260 words: 0x0000,0x0001,0x0002,0x0003 (sof on first), then samples 36..291 (eof on 291); missed_triggers=0.
- Early trigger: edge at sample 10 (still in FILL) → no frame, missed_triggers=1. A later edge at sample 200 gives a frame starting with sample 136.
- Backpressure: same stimulus as the ramp test, dout_ready toggling 1,0,0,1,… → identical word sequence. dout, dout_sof and dout_eof stay stable while stalled; no drops or duplicates.
- Retrigger/wrap: held-high trigger produces only one edge. Second edge during POST → missed_triggers=1. Next frame taken after the 64-sample refill, with wp wrapped past 511, still holds contiguous ramp values.
- enable gating: enable=1 every 3rd cycle → frame contains only strobed samples, same ordering as the ramp test; an edge on a cycle with enable=0 is ignored.
- Async reset: assert reset=0 at header word 2 → dout_valid=0 and missed_triggers=0 immediately. After release, busy=1 for exactly 64 enable cycles, then 0.
